tristate_bus_arbiter: RTL and testbench
=======================================

# tristate_bus_arbiter

- Round-robin arbiter sharing one tri-state bus among N requesters.
- Each requester drives the bus through its own `bufif0` driver. This block generates the active-low enables for those drivers.
- Every ownership change passes through at least one all-high-Z turnaround cycle (break-before-make), so two drivers never overlap.
- Sits between requesting agents and the bank of `bufif0` gates on the shared bus.

## Interface

Parameters:
- `N`, 4 — number of requesters (2..16).
- `MAX_HOLD`, 8 — maximum consecutive OWN cycles per grant (≥1); used only with the timeout feature.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  — system clock; all state changes on its rising edge.
- `reset`  input  1  — synchronous, active-high reset.
- `req`  input  N  — request per requester; level-sensitive; held high while bus is wanted.
- `grant`  output  N  — one-hot (or zero) current owner, registered.
- `oe_n`  output  N  — active-low enables; `oe_n[i]` connects to the `enable` of requester i's `bufif0`. At most one bit is low at any time.
- `owner_id`  output  $clog2(N)  — binary index of the granted requester; 0 when `grant` is zero.
- `busy`  output  1  — high in TURN and OWN.

## Operation

- States: IDLE, TURN, OWN (registered).
- Reset values:
  - state = IDLE, `grant` = 0, `oe_n` = all ones, `owner_id` = 0, `busy` = 0.
  - Round-robin pointer `last` = N-1, so requester 0 has highest priority after reset.
- IDLE:
  - All `oe_n` high.
  - If `req` ≠ 0, winner = first set bit scanning `last+1, last+2, …` modulo N (wraps).
  - Next state: TURN with `grant` = onehot(winner), `owner_id` = winner, `last` = winner.
  - Otherwise stay in IDLE.
- TURN:
  - Exactly one cycle; `oe_n` still all high (bus high-Z).
  - If `req[owner]` is still high, go to OWN.
  - Otherwise go to IDLE and clear `grant`; the owner never drives.
- OWN:
  - `oe_n[owner]` = 0; all other bits high.
  - Hold counter starts at 0 on entry and increments every OWN cycle.
  - Release when `req[owner]` = 0. With the timeout feature, also release when counter = MAX_HOLD-1 (that cycle is the last driven cycle).
  - On release, the next state is IDLE: `grant` = 0, `oe_n` all high, `owner_id` = 0.
- Fairness: after a release or timeout, the former owner has lowest priority for the next arbitration.
- Simultaneous requests: resolved only by the round-robin scan; requests arriving during TURN or OWN wait.
- `reset` asserted in any state: the next edge forces reset values, releasing the bus immediately.

## Timing

- Request to drive:
  - `req[i]` high and sampled in IDLE at edge t: TURN after edge t.
  - `oe_n[i]` low after edge t+1, i.e. 2 cycles of latency.
- Release:
  - `req[owner]` low sampled at edge t in OWN: `oe_n` all high after edge t.
  - At least 2 high-Z cycles separate consecutive owners (IDLE + TURN).
- With the timeout feature, an always-requesting owner drives for exactly MAX_HOLD cycles, then the bus is high-Z for ≥2 cycles.
- All outputs are registered; there are no combinational paths from `req` to outputs.

## Configuration

- Macro `TSBUS_TIMEOUT_EN`.
- Defined: the MAX_HOLD hold counter and forced release are compiled in.
- Undefined:
  - Counter logic is absent and MAX_HOLD is ignored.
  - The owner keeps the bus for as long as `req[owner]` stays high; the only release is `req` deassertion or reset.

## Test plan

- Reset then idle: assert `reset` 2 cycles, `req` = 0 → `oe_n` = 4'b1111, `grant` = 0, `busy` = 0 every cycle.
- Single request: `req` = 4'b0100 → `grant` = 4'b0100 one cycle later with `oe_n` = 4'b1111; the next cycle `oe_n` = 4'b1011, `owner_id` = 2. Drop `req` → `oe_n` = 4'b1111 on the next edge.
- Round-robin with N=4:
  - Hold `req` = 4'b1111 (timeout enabled, MAX_HOLD=3).
  - Expected owners in order: 0, 1, 2, 3, 0.
  - Each owner is driven exactly 3 cycles, with 2 all-high-Z cycles between owners.
  - `oe_n` never has two bits low at once.
- Withdraw in TURN: `req` = 4'b0001 for one cycle only → TURN, then IDLE; `oe_n[0]` never goes low.
- Reset mid-OWN: owner 1 driving, pulse `reset` → `oe_n` = 4'b1111 after that edge. The next `req` = 4'b0011 grants requester 0 first.
- Timeout compiled out: `req` = 4'b0011 held 20 cycles → requester 0 drives all cycles from the 3rd onward; `grant[1]` never asserts.

Source files
------------

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter generating active-low bufif0 enables for a shared tri-state bus,
// with a break-before-make turnaround cycle. Optional hold timeout: define TSBUS_TIMEOUT_EN.
module tristate_bus_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         oe_n,
  output logic [$clog2(N)-1:0] owner_id,
  output logic                 busy
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_OWN  = 2'd2
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [IW-1:0] last_r;
  logic [IW-1:0] last_nxt_s;
  logic [IW-1:0] winner_s;
  logic [IW-1:0] owner_id_r;
  logic [IW-1:0] owner_nxt_s;
  logic [N-1:0]  grant_r;
  logic [N-1:0]  grant_nxt_s;
  logic [N-1:0]  oe_n_r;
  logic [N-1:0]  oe_n_nxt_s;
  logic          busy_r;
  logic          busy_nxt_s;
  logic          timeout_s;

  // First requester found scanning last+1, last+2, ... modulo N.
  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] last);
    logic [IW-1:0] w;
    logic [IW-1:0] idx;
    logic          found;
    w     = last;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last) + k) % N);
      if (!found && r[idx]) begin
        w     = idx;
        found = 1'b1;
      end else begin
        w     = w;
      end
    end
    return w;
  endfunction

  assign winner_s = rr_pick(req, last_r);

`ifdef TSBUS_TIMEOUT_EN
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  logic [CW-1:0] hold_cnt_r;

  // Hold counter: zero outside OWN, counts driven cycles while owning.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt_r <= {CW{1'b0}};
    end else if (state_r == ST_OWN) begin
      hold_cnt_r <= hold_cnt_r + CW'(1'b1);
    end else begin
      hold_cnt_r <= {CW{1'b0}};
    end
  end

  assign timeout_s = (state_r == ST_OWN) && (hold_cnt_r == CW'(MAX_HOLD - 1));
`else
  logic unused_max_hold_s;
  assign timeout_s         = 1'b0;
  assign unused_max_hold_s = (MAX_HOLD > 0);
`endif

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      last_r     <= IW'(N - 1);
      grant_r    <= {N{1'b0}};
      oe_n_r     <= {N{1'b1}};
      owner_id_r <= {IW{1'b0}};
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      last_r     <= last_nxt_s;
      grant_r    <= grant_nxt_s;
      oe_n_r     <= oe_n_nxt_s;
      owner_id_r <= owner_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  // Next-state decode; TURN is always a single cycle.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (|req) state_nxt_s = ST_TURN;
        else      state_nxt_s = ST_IDLE;
      end
      ST_TURN: begin
        if (req[owner_id_r]) state_nxt_s = ST_OWN;
        else                 state_nxt_s = ST_IDLE;
      end
      ST_OWN: begin
        if (!req[owner_id_r] || timeout_s) state_nxt_s = ST_IDLE;
        else                               state_nxt_s = ST_OWN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output values for the upcoming state; the enable opens only in OWN.
  always_comb begin
    grant_nxt_s = {N{1'b0}};
    oe_n_nxt_s  = {N{1'b1}};
    owner_nxt_s = {IW{1'b0}};
    busy_nxt_s  = 1'b0;
    last_nxt_s  = last_r;
    case (state_nxt_s)
      ST_TURN: begin
        grant_nxt_s = {{(N-1){1'b0}}, 1'b1} << winner_s;
        owner_nxt_s = winner_s;
        busy_nxt_s  = 1'b1;
        last_nxt_s  = winner_s;
      end
      ST_OWN: begin
        grant_nxt_s = grant_r;
        oe_n_nxt_s  = ~grant_r;
        owner_nxt_s = owner_id_r;
        busy_nxt_s  = 1'b1;
      end
      default: begin
        grant_nxt_s = {N{1'b0}};
        oe_n_nxt_s  = {N{1'b1}};
      end
    endcase
  end

  assign grant    = grant_r;
  assign oe_n     = oe_n_r;
  assign owner_id = owner_id_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Self-checking bench for tristate_bus_arbiter (N=4, MAX_HOLD=3); follows TSBUS_TIMEOUT_EN.
module tb_tristate_bus_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 3;
`ifdef TSBUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] grant;
  logic [N-1:0] oe_n;
  logic [1:0]   owner_id;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: owner (-1 = bus free), age 0 = turnaround, age k>=1 = k-th driven cycle.
  int m_owner = -1;
  int m_age   = 0;
  int m_last  = N - 1;

  tristate_bus_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .reset(reset), .req(req),
    .grant(grant), .oe_n(oe_n), .owner_id(owner_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic [N-1:0] r);
    if (rst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_age   = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (m_owner < 0 && r[(m_last + k) % N]) m_owner = (m_last + k) % N;
      end
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_age  = 0;
      end
    end else if (m_age == 0) begin
      if (r[m_owner]) m_age = 1;
      else            m_owner = -1;
    end else begin
      if (!r[m_owner] || (TO_EN && m_age == MAXH)) m_owner = -1;
      else                                        m_age++;
    end
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    logic [N-1:0] eo;
    eg = '0;
    eo = '1;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    if (m_owner >= 0 && m_age >= 1) eo = ~eg;
    chk("grant", 32'(grant), 32'(eg));
    chk("oe_n", 32'(oe_n), 32'(eo));
    chk("owner_id", 32'(owner_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
    chk("oe_n_single_low", ($countones(~oe_n) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic step(input logic rst, input logic [N-1:0] r);
    reset = rst;
    req   = r;
    @(posedge clk);
    model_edge(rst, r);
    #1;
    check_all();
  endtask

  initial begin
    // Reset then idle
    #1;
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    chk("reset_oe_n", 32'(oe_n), 32'hF);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000);

    // Single request on requester 2
    step(1'b0, 4'b0100);
    chk("single_turn_grant", 32'(grant), 32'h4);
    chk("single_turn_oe_n", 32'(oe_n), 32'hF);
    step(1'b0, 4'b0100);
    chk("single_own_oe_n", 32'(oe_n), 32'hB);
    chk("single_own_id", 32'(owner_id), 32'd2);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0000);
    chk("single_release_oe_n", 32'(oe_n), 32'hF);
    step(1'b0, 4'b0000);

    // Round robin from reset with all requesting
    step(1'b1, 4'b0000);
    for (int i = 0; i < 24; i++) step(1'b0, 4'b1111);
    step(1'b0, 4'b0000);

    // Withdraw during turnaround
    step(1'b0, 4'b0001);
    step(1'b0, 4'b0000);
    chk("withdraw_idle_oe_n", 32'(oe_n), 32'hF);
    step(1'b0, 4'b0000);

    // Reset while requester 1 owns the bus
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0010);
    chk("mid_own_oe_n", 32'(oe_n), 32'hD);
    step(1'b1, 4'b0010);
    chk("reset_release_oe_n", 32'(oe_n), 32'hF);
    step(1'b0, 4'b0011);
    chk("after_reset_winner", 32'(owner_id), 32'd0);

    // Two requesters held for 20 cycles
    for (int i = 0; i < 20; i++) step(1'b0, 4'b0011);
    step(1'b0, 4'b0000);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      logic         rs;
      r  = N'($urandom_range(0, 15));
      rs = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) != 0 && m_owner >= 0) r[m_owner] = 1'b1;
      step(rs, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
